universal_down_counter: RTL and testbench

- Loadable, cascadable down counter with borrow-out.
- Counterpart of the 4-bit universal up counter: it counts toward zero rather than all-ones, and raises bout instead of cout.
- Used as a programmable interval timer / event divider in the ALU block, with one-shot or auto-reload operation.
- Stages chain by wiring bout of the lower stage to count of the next stage.

---
 rtl/universal_down_counter.sv | 71 +++++++
 tb/tb_universal_down_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_down_counter.sv
// Loadable, cascadable down counter with borrow-out.
// One-shot or auto-reload; chain stages via bout -> count.
module universal_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             count,
    input  logic             reload_en,
    output logic [WIDTH-1:0] acount,
    output logic             bout,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acount_nx;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nx;
    logic             done_nx;
    logic             zero;

    assign zero = (acount == '0);
    assign bout = (state == RUN) & count & zero & ~load;

    always_comb begin
        state_nx  = state;
        acount_nx = acount;
        reload_nx = reload_q;
        done_nx   = done;
        if (load) begin
            acount_nx = din;
            reload_nx = din;
            state_nx  = RUN;
            done_nx   = 1'b0;
        end else if (state == RUN && count) begin
            if (!zero) begin
                acount_nx = acount - 1'b1;
            end else if (reload_en) begin
                acount_nx = reload_q;
            end else begin
                state_nx = EXPIRED;
                done_nx  = 1'b1;
            end
        end
    end

    // Reset is synchronous: it only takes effect on a clk edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            acount   <= '0;
            reload_q <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            acount   <= acount_nx;
            reload_q <= reload_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_universal_down_counter.sv
// Directed self-checking bench for universal_down_counter,
// including a two-stage cascade.
module tb_universal_down_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       load;
    logic       count;
    logic       reload_en;
    logic [3:0] acount;
    logic       bout;
    logic       done;

    logic       c_load;
    logic       c_count;
    logic [3:0] lo_din;
    logic [3:0] hi_din;
    logic [3:0] lo_acount;
    logic [3:0] hi_acount;
    logic       lo_bout;
    logic       hi_bout;
    logic       lo_done;
    logic       hi_done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    universal_down_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .load     (load),
        .count    (count),
        .reload_en(reload_en),
        .acount   (acount),
        .bout     (bout),
        .done     (done)
    );

    universal_down_counter #(.WIDTH(4)) u_lo (
        .clk      (clk),
        .reset    (reset),
        .din      (lo_din),
        .load     (c_load),
        .count    (c_count),
        .reload_en(1'b1),
        .acount   (lo_acount),
        .bout     (lo_bout),
        .done     (lo_done)
    );

    universal_down_counter #(.WIDTH(4)) u_hi (
        .clk      (clk),
        .reset    (reset),
        .din      (hi_din),
        .load     (c_load),
        .count    (lo_bout),
        .reload_en(1'b1),
        .acount   (hi_acount),
        .bout     (hi_bout),
        .done     (hi_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input logic [3:0] a,
                           input logic b, input logic d);
        chk({tag, "_acount"}, 32'(acount), 32'(a));
        chk({tag, "_bout"}, 32'(bout), 32'(b));
        chk({tag, "_done"}, 32'(done), 32'(d));
    endtask

    initial begin
        reset     = 1'b0;
        din       = 4'd9;
        load      = 1'b1;
        count     = 1'b0;
        reload_en = 1'b0;
        c_load    = 1'b0;
        c_count   = 1'b0;
        lo_din    = 4'd3;
        hi_din    = 4'd1;

        // 1: reset beats load
        tick();
        tick();
        expect3("rst", 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        load  = 1'b0;
        count = 1'b1;
        #1;
        chk("idle_bout", 32'(bout), 32'd0);
        tick();
        tick();
        expect3("idle", 4'd0, 1'b0, 1'b0);

        // 2: one-shot
        din  = 4'd3;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect3("os3", 4'd3, 1'b0, 1'b0);
        tick();
        expect3("os2", 4'd2, 1'b0, 1'b0);
        tick();
        expect3("os1", 4'd1, 1'b0, 1'b0);
        tick();
        expect3("os0", 4'd0, 1'b1, 1'b0);
        tick();
        expect3("os_exp", 4'd0, 1'b0, 1'b1);
        tick();
        expect3("os_hold", 4'd0, 1'b0, 1'b1);

        // 3: auto-reload, period 3
        din       = 4'd2;
        reload_en = 1'b1;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic [3:0] e;
            e = 4'(2 - (i % 3));
            expect3($sformatf("ar%0d", i), e, e == 4'd0, 1'b0);
            tick();
        end

        // 4: hold and priority
        din   = 4'd5;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        count = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect3($sformatf("hold%0d", i), 4'd5, 1'b0, 1'b0);
        end
        din   = 4'd7;
        load  = 1'b1;
        count = 1'b1;
        #1;
        chk("ldcnt_bout", 32'(bout), 32'd0);
        tick();
        chk("ldcnt_acount", 32'(acount), 32'd7);
        din = 4'd0;
        tick();
        chk("ld0_acount", 32'(acount), 32'd0);
        din = 4'd4;
        #1;
        chk("ld_at0_bout", 32'(bout), 32'd0);
        tick();
        load = 1'b0;
        expect3("ld_at0", 4'd4, 1'b0, 1'b0);

        // 5: mid-count reset
        reload_en = 1'b0;
        din       = 4'd15;
        load      = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("mid_acount", 32'(acount), 32'd11);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect3("mid_rst", 4'd0, 1'b0, 1'b0);
        tick();
        expect3("mid_idle", 4'd0, 1'b0, 1'b0);
        din  = 4'd1;
        load = 1'b1;
        tick();
        load = 1'b0;
        expect3("re1", 4'd1, 1'b0, 1'b0);
        tick();
        expect3("re0", 4'd0, 1'b1, 1'b0);
        tick();
        expect3("re_exp", 4'd0, 1'b0, 1'b1);

        // 6: cascade, upper borrows once per 8 lower counts
        c_load = 1'b1;
        tick();
        c_load  = 1'b0;
        c_count = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("lo_bout%0d", k), 32'(lo_bout),
                32'((k % 4) == 3));
            chk($sformatf("hi_bout%0d", k), 32'(hi_bout),
                32'((k % 8) == 7));
            tick();
        end
        chk("hi_done", 32'(hi_done), 32'd0);

        // din=0 one-shot
        din   = 4'd0;
        load  = 1'b1;
        count = 1'b0;
        tick();
        load = 1'b0;
        expect3("z_ld", 4'd0, 1'b0, 1'b0);
        count = 1'b1;
        #1;
        chk("z_bout", 32'(bout), 32'd1);
        tick();
        expect3("z_exp", 4'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
